// File: rtl/psram_arbiter_if.sv
// Requester and controller-side signal bundle for psram_arbiter.
// slave = arbiter view; master = requesters plus PSRAM controller view.
interface psram_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [3:0]  req_be;
  logic [45:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [15:0] rdata;
  logic        busy;
  logic        ctrlr_good;
  logic        op_begun;
  logic        op_finished;
  logic        data_ok;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic        ub;
  logic        lb;
  logic        burst;
  logic [22:0] addr;
  logic [15:0] data_out;

  modport slave (
    input  req, req_we, req_be, req_addr, req_wdata,
    input  ctrlr_good, op_begun, op_finished, data_ok, data_in,
    output gnt, done, err, rdata, busy,
    output wr, rd, ub, lb, burst, addr, data_out
  );

  modport master (
    output req, req_we, req_be, req_addr, req_wdata,
    output ctrlr_good, op_begun, op_finished, data_ok, data_in,
    input  gnt, done, err, rdata, busy,
    input  wr, rd, ub, lb, burst, addr, data_out
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter and single-operation sequencer for the PSRAM controller.
// Controller-facing strobes decode only from registered state and latched request fields.
module psram_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 11
) (
  input  logic           clk,
  input  logic           reset,
  psram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [22:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              abort_q, abort_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              win;
  logic              timeout;
  logic [1:0]        owner_oh;

  // Sole requester wins; on contention the port that did not win last time goes.
  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    case (r)
      2'b01:   pick_winner = 1'b0;
      2'b10:   pick_winner = 1'b1;
      default: pick_winner = ~last;
    endcase
  endfunction

  assign timeout = (TIMEOUT_CYCLES != 0) && (tmr_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmr_d   = tmr_q;
    abort_d = abort_q;
    gnt_d   = 2'b00;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ctrlr_good && (bus.req != 2'b00)) begin
          win     = pick_winner(bus.req, last_q);
          owner_d = win;
          last_d  = win;
          we_d    = win ? bus.req_we[1]          : bus.req_we[0];
          be_d    = win ? bus.req_be[3:2]        : bus.req_be[1:0];
          addr_d  = win ? bus.req_addr[45:23]    : bus.req_addr[22:0];
          wdata_d = win ? bus.req_wdata[31:16]   : bus.req_wdata[15:0];
          gnt_d   = win ? 2'b10 : 2'b01;
          tmr_d   = '0;
          abort_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d = tmr_q + TMR_W'(1);
        // A combined begin+finish skips WAIT; otherwise the watchdog outranks a plain begin.
        if (bus.op_begun && bus.op_finished) begin
          state_d = DONE;
        end else if (timeout) begin
          abort_d = 1'b1;
          state_d = DONE;
        end else if (bus.op_begun) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (bus.op_finished) begin
          state_d = DONE;
        end else if (timeout) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (((state_q == ISSUE) || (state_q == WAIT)) && bus.data_ok && !we_q) begin
      rdata_d = bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tmr_q   <= '0;
      abort_q <= 1'b0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tmr_q   <= tmr_d;
      abort_q <= abort_d;
      gnt_q   <= gnt_d;
    end
  end

  assign owner_oh     = owner_q ? 2'b10 : 2'b01;
  assign bus.gnt      = gnt_q;
  assign bus.done     = (state_q == DONE) ? owner_oh : 2'b00;
  assign bus.err      = ((state_q == DONE) && abort_q) ? owner_oh : 2'b00;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.rd       = (state_q == ISSUE) && !we_q;
  assign bus.wr       = (state_q == ISSUE) && we_q;
  assign bus.ub       = be_q[1];
  assign bus.lb       = be_q[0];
  assign bus.burst    = 1'b0;
  assign bus.addr     = addr_q;
  assign bus.data_out = wdata_q;

endmodule
